// File: rtl/wb_host_pkg.sv
// wb_host_pkg: shared widths, state encoding and default error word for wb_host_sequencer
package wb_host_pkg;
    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;
    localparam logic [WB_DAT_W-1:0] ERR_DATA_DEFAULT = 32'hBADC_0FFE;
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
endpackage

// File: rtl/wb_host_sequencer.sv
// wb_host_sequencer: single-transfer Wishbone classic initiator with cmd/rsp valid-ready handshakes and ack timeout
module wb_host_sequencer
    import wb_host_pkg::*;
#(
    parameter int unsigned           TIMEOUT_CYCLES = 256,
    parameter logic [WB_DAT_W-1:0]   ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [WB_SEL_W-1:0] cmd_sel_i,
    input  logic [WB_ADR_W-1:0] cmd_adr_i,
    input  logic [WB_DAT_W-1:0] cmd_dat_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [WB_DAT_W-1:0] rsp_dat_o,
    output logic                rsp_err_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    input  logic                wbm_ack_i,
    input  logic [WB_DAT_W-1:0] wbm_dat_i,
    output logic                busy_o
);
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          expired;
    assign expired     = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign cmd_ready_o = (state == IDLE) && !wb_rst_i;
    assign busy_o      = state != IDLE;
    // Sequencer: launch the bus cycle, wait for ack or timeout, then hold the response until consumed
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid_i) begin
                    wbm_we_o  <= cmd_we_i;
                    wbm_sel_o <= cmd_sel_i;
                    wbm_adr_o <= cmd_adr_i;
                    wbm_dat_o <= cmd_dat_i;
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    cnt       <= '0;
                    state     <= BUS;
                end
                BUS: if (wbm_ack_i || expired) begin
                    wbm_cyc_o   <= 1'b0;
                    wbm_stb_o   <= 1'b0;
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= !wbm_ack_i;
                    rsp_dat_o   <= !wbm_ack_i ? ERR_DATA : wbm_we_o ? '0 : wbm_dat_i;
                    state       <= RESP;
                end else if (cnt != '1) begin
                    cnt <= cnt + 1'b1;
                end
                RESP: if (rsp_ready_i) begin
                    rsp_valid_o <= 1'b0;
                    rsp_err_o   <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/wb_host_sequencer.md
Name: wb_host_sequencer

Overview:
- Wishbone classic single-transfer initiator (master) driving the crossbar_wrapper Wishbone slave port. Used for standalone bring-up, and for LA/IO-driven test access when the management SoC is not the bus owner.
- Accepts one command at a time over a valid/ready interface.
- Runs one cyc/stb cycle per command and returns read data or a timeout error over a valid/ready response interface.

Parameters:
- TIMEOUT_CYCLES, 256: maximum cycles to wait for ack while stb is asserted; 0 disables the timeout.
- ERR_DATA, 32'hBADC_0FFE: value returned on rsp_dat_o when a transfer times out.

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  asynchronous active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_sel_i  in  4  byte selects
- cmd_adr_i  in  32  byte address
- cmd_dat_i  in  32  write data
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed
- rsp_dat_o  out  32  read data; 0 for writes; ERR_DATA on timeout
- rsp_err_o  out  1  transfer timed out
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  4  byte selects
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_ack_i  in  1  slave acknowledge
- wbm_dat_i  in  32  slave read data
- busy_o  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (asynchronous, wb_rst_i=1):
  - State goes to IDLE.
  - All outputs 0, except cmd_ready_o=0 while reset is asserted and 1 from the first cycle after release.
  - The timeout counter clears to 0.
- FSM states are IDLE, BUS and RESP.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i && cmd_ready_o at edge N: register we/sel/adr/dat into the wbm_* outputs, assert wbm_cyc_o and wbm_stb_o from after edge N, and go to BUS.
- BUS:
  - cmd_ready_o=0. cyc, stb, adr, sel, we and dat are held stable.
  - The timeout counter increments every cycle.
  - Ack: on wbm_ack_i=1 sampled at edge M:
    - cyc and stb go to 0 after edge M, giving exactly one stb-ack overlap.
    - rsp_dat_o is set to wbm_dat_i for a read, or 0 for a write; rsp_err_o=0.
    - rsp_valid_o=1 after edge M; go to RESP.
  - Timeout: the counter reaches TIMEOUT_CYCLES-1 with no ack, with TIMEOUT_CYCLES>0:
    - cyc and stb are dropped.
    - rsp_dat_o=ERR_DATA, rsp_err_o=1, rsp_valid_o=1; go to RESP.
  - Ack and timeout in the same cycle: ack wins, and the response is a normal one.
- RESP:
  - rsp_* are held stable until rsp_valid_o && rsp_ready_i.
  - At that edge: rsp_valid_o goes to 0, rsp_err_o is cleared, and the state returns to IDLE. cmd_ready_o=1 from the following cycle.
  - Minimum command-to-command spacing is 3 cycles.
- wbm_ack_i while in IDLE or RESP: ignored, with no state change.
- wbm_dat_i is sampled only on the ack edge.
- Reset mid-transfer drops cyc/stb immediately (asynchronously). No response is produced for the aborted command.
- Timeout counter:
  - Width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
  - Clears on entry to BUS and saturates.
  - Never wraps.
- Single outstanding transfer only; no pipelined mode and no burst (cti/bte are not driven).

Decomposition:
- Package wb_host_pkg:
  - State enum: IDLE, BUS, RESP.
  - WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4.
  - Default ERR_DATA constant.
- Single module. The timeout counter is too small to justify a sub-module.

Test Plan:
- Read, ack after 2 wait states:
  - Stimulus: cmd adr=0x3000_0004, we=0, sel=0xF; slave acks on the 3rd stb cycle with dat 0x1234_5678.
  - Required response: cyc/stb high for exactly 3 cycles; rsp_valid=1, rsp_dat=0x1234_5678, err=0.
- Write, zero-wait ack:
  - Stimulus: cmd adr=0x3000_0010, dat=0xA5A5_A5A5, sel=0x3; slave acks in the first stb cycle.
  - Required response: wbm_we=1, wbm_sel=0x3, wbm_dat=0xA5A5_A5A5 for 1 cycle; rsp_dat=0, err=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, no ack.
  - Required response: stb high exactly 8 cycles then 0; rsp_err=1, rsp_dat=0xBADC_0FFE.
  - Re-run with ack arriving on the 8th cycle: err=0 and real data returned.
- Response backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles after the ack, with a second command presented.
  - Required response: rsp_* stable, cmd_ready=0 and no new cyc during the stall; the second command is accepted the cycle after the handshake.
- Reset mid-transfer and stray acks:
  - Stimulus: assert wb_rst_i in the 2nd stb cycle.
  - Required response: cyc/stb go to 0 asynchronously; no rsp_valid after release; cmd_ready=1 one cycle after release.
  - Stimulus: stray wbm_ack_i pulses while in IDLE or RESP. Required response: no state change.
